mp_sub_seq: RTL and testbench
=============================

MP_SUB_SEQ -- requirements
Module: mp_sub_seq

Interface
REQ-001 Parameter: LEN_W, default 4, width of the word-count input; maximum operand length is 2^LEN_W-1 words of 64 bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begins an operation; sampled only in IDLE.
REQ-005 len  input  LEN_W  number of 64-bit words in the operation; sampled with start.
REQ-006 bin_init  input  1  borrow-in for the least significant word; sampled with start.
REQ-007 in_valid  input  1  an operand word pair is present on x_in/y_in.
REQ-008 in_ready  output  1  the block accepts the word pair this cycle.
REQ-009 x_in, y_in  input  64 each  minuend and subtrahend word, least significant word first.
REQ-010 out_valid  output  1  d_out holds a valid difference word.
REQ-011 out_ready  input  1  the downstream consumer takes d_out this cycle.
REQ-012 d_out  output  64  registered difference word.
REQ-013 out_last  output  1  d_out is the final word of the operation.
REQ-014 done  output  1  one-cycle pulse marking completion of the operation.
REQ-015 bout  output  1  final borrow-out, held stable until the next accepted start.
REQ-016 zero  output  1  all result words were zero, held stable until the next accepted start.
REQ-017 busy  output  1  state is not IDLE.

Function
REQ-018 Arithmetic: each word uses the team's 64-bit CLS.
- Operands x_in, y_in, with the borrow register as bin.
- Word borrow-out = GG | (GP & bin); {borrow, d} = x - y - bin, modulo 2^64.
REQ-019 FSM states and transitions:
- IDLE -> RUN on start with len != 0.
- IDLE -> DONE on start with len == 0.
- RUN -> DONE on the edge where the last word's output handshake completes.
- DONE -> IDLE unconditionally after one cycle.
REQ-020 On an accepted start:
- borrow register <= bin_init.
- remaining-word counter <= len.
- zero register <= 1.
REQ-021 start SHALL be ignored in RUN and DONE.
REQ-022 Input handshake: in_ready = (state==RUN) && (remaining input words > 0) && (!out_valid || out_ready).
REQ-023 A word is accepted on an edge with in_valid && in_ready; on that edge:
- d_out, out_valid, borrow and zero are all updated.
- zero <= zero & (d==0).
- out_last <= 1 if this is the final word.
REQ-024 Latency and throughput:
- Latency from input acceptance to out_valid: 1 cycle.
- Sustained throughput: 1 word/cycle while out_ready stays high.
REQ-025 Backpressure: with out_valid=1 and out_ready=0, d_out and out_last SHALL hold stable and in_ready SHALL be 0.
REQ-026 Simultaneous events: an output handshake and a new input acceptance on the same edge SHALL load the new word into the output register with out_valid remaining 1.
REQ-027 out_valid SHALL clear after an output handshake when no new word is accepted on the same edge.
REQ-028 DONE state:
- done=1 for exactly one cycle.
- bout = final borrow register.
- zero = final zero register.
REQ-029 len==0 operation: no input is requested; done pulses on the cycle after start, with bout=bin_init and zero=1.
REQ-030 in_valid outside RUN SHALL have no effect.

Reset
REQ-031 While rst_n=0, including mid-operation, the block SHALL immediately force:
- state IDLE.
- out_valid=0, d_out=0, out_last=0.
- done=0, bout=0, zero=0, busy=0, in_ready=0.
- borrow register 0, counter 0.
REQ-032 After rst_n deasserts, the first start SHALL begin a fresh operation with no residue from the aborted one.

Verification
REQ-033 len=1, bin_init=0, x=5, y=3 -> d_out=2, out_last=1; done pulse with bout=0, zero=0.
REQ-034 len=2, bin_init=0, x={w0=0, w1=1}, y={w0=1, w1=0}:
- word0 d=0xFFFF_FFFF_FFFF_FFFF.
- word1 d=0.
- done with bout=0, zero=0.
REQ-035 len=1: x=0, y=0 -> d=0, zero=1, bout=0; then x=0, y=1 -> d=0xFFFF_FFFF_FFFF_FFFF, zero=0, bout=1.
REQ-036 len=3 with out_ready held low 3 cycles after the first output:
- in_ready=0 and d_out stable throughout the stall.
- all 3 words delivered in order with no loss or duplication; done once.
REQ-037 len=0, bin_init=1 -> no in_ready; done one cycle after start with bout=1, zero=1.
REQ-038 rst_n pulsed low during RUN after 1 of 4 words -> all outputs 0 immediately; a subsequent start with len=1, x=9, y=4 -> d=5, bout=0.

Source files
------------

// File: rtl/mp_sub_seq.sv
// Multi-precision 64-bit subtractor, one word per cycle, LSW first, with a
// registered output stage, borrow chaining across words and a zero-result flag.
module mp_sub_seq #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             bin_init,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      x_in,
   input  logic [63:0]      y_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      d_out,
   output logic             out_last,
   output logic             done,
   output logic             bout,
   output logic             zero,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [LEN_W-1:0] cnt;
   logic             borrow_q, zero_q;
   logic             start_acc, in_acc, out_hs;

   // Word subtractor: borrow-lookahead over 16 nibble groups, then across groups.
   logic [63:0] g, p, d;
   logic [15:0] ng, np;
   logic        gg, gp, word_bout;

   assign g = ~x_in & y_in;
   assign p = ~(x_in ^ y_in);
   assign d = x_in - y_in - {63'd0, borrow_q};

   always_comb begin
      for (int n = 0; n < 16; n++) begin
         ng[n] = 1'b0;
         np[n] = 1'b1;
         for (int b = 0; b < 4; b++) begin
            ng[n] = g[4*n+b] | (p[4*n+b] & ng[n]);
            np[n] = p[4*n+b] & np[n];
         end
      end
      gg = 1'b0;
      gp = 1'b1;
      for (int n = 0; n < 16; n++) begin
         gg = ng[n] | (np[n] & gg);
         gp = np[n] & gp;
      end
      word_bout = gg | (gp & borrow_q);
   end

   assign start_acc = (state == IDLE) && start;
   assign out_hs    = out_valid && out_ready;
   assign in_acc    = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (len != '0) ? RUN : DONE;
         RUN:     if (out_hs && out_last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      done     = (state == DONE);
      in_ready = (state == RUN) && (cnt != '0) && (!out_valid || out_ready);
   end

   assign bout = borrow_q;
   assign zero = zero_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         borrow_q  <= 1'b0;
         zero_q    <= 1'b0;
         d_out     <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (start_acc) begin
         cnt       <= len;
         borrow_q  <= bin_init;
         zero_q    <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (in_acc) begin
         // New word replaces the output register even when it is drained this edge.
         cnt       <= cnt - 1'b1;
         borrow_q  <= word_bout;
         zero_q    <= zero_q & (d == 64'd0);
         d_out     <= d;
         out_valid <= 1'b1;
         out_last  <= (cnt == LEN_W'(1));
      end else if (out_hs) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mp_sub_seq.sv
// Directed-vector bench for mp_sub_seq: per-scenario tasks with inline checks.
module tb_mp_sub_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  len = '0;
   logic        bin_init = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] x_in = '0, y_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] d_out;
   logic        out_last, done, bout, zero, busy;

   int checks = 0;
   int failures = 0;

   logic [63:0] xv [16];
   logic [63:0] yv [16];
   logic [63:0] got_d [16];
   logic        got_last [16];
   int          n_out, done_cnt, done_at, stall_viol, acc_first, acc_last, n_acc;
   logic        done_bout, done_zero, any_inready;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   always #5 clk = ~clk;

   mp_sub_seq #(.LEN_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bin_init(bin_init),
      .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
      .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out), .out_last(out_last),
      .done(done), .bout(bout), .zero(zero), .busy(busy)
   );

   // Runs one operation from posedge+1; stalls out_ready for 'stall' cycles after the first output.
   task automatic run_op(input int n, input logic b, input int stall);
      int idx = 0, cyc = 0, stall_left = 0, post = 0;
      bit stall_used = 0;
      logic [63:0] held = '0;
      n_out = 0; done_cnt = 0; done_at = -1; stall_viol = 0; n_acc = 0;
      acc_first = -1; acc_last = -1; any_inready = 1'b0;
      done_bout = 1'bx; done_zero = 1'bx;
      start = 1'b1; len = 4'(n); bin_init = b;
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc < 100 && post < 3) begin
         if (done) begin
            if (done_cnt == 0) done_at = cyc;
            done_cnt++; done_bout = bout; done_zero = zero;
         end
         if (done_cnt > 0) post++;
         if (stall > 0 && !stall_used && n_out >= 1) begin
            stall_used = 1; stall_left = stall; held = d_out;
         end
         out_ready = (stall_left == 0);
         in_valid  = (idx < n);
         x_in = (idx < 16) ? xv[idx] : '0;
         y_in = (idx < 16) ? yv[idx] : '0;
         #1;
         if (in_ready) any_inready = 1'b1;
         if (stall_left > 0) begin
            if (in_ready !== 1'b0 || d_out !== held) stall_viol++;
            stall_left--;
         end
         if (out_valid && out_ready) begin
            if (n_out < 16) begin got_d[n_out] = d_out; got_last[n_out] = out_last; end
            n_out++;
         end
         if (in_valid && in_ready) begin
            if (acc_first < 0) acc_first = cyc;
            acc_last = cyc; n_acc++; idx++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (out_valid !== 1'b0 || d_out !== 64'd0 || out_last !== 1'b0) begin
         failures++; $display("FAIL reset_out got=%b/%h/%b exp=0/0/0", out_valid, d_out, out_last); end
      checks++; if (done !== 1'b0 || bout !== 1'b0 || zero !== 1'b0 || in_ready !== 1'b0) begin
         failures++; $display("FAIL reset_flags got=%b%b%b%b exp=0000", done, bout, zero, in_ready); end
   endtask

   task automatic test_single();
      xv[0] = 64'd5; yv[0] = 64'd3;
      run_op(1, 1'b0, 0);
      checks++; if (n_out !== 1 || got_d[0] !== 64'd2 || got_last[0] !== 1'b1) begin
         failures++; $display("FAIL single_word got=%0d/%h/%b exp=1/2/1", n_out, got_d[0], got_last[0]); end
      checks++; if (done_cnt !== 1 || done_bout !== 1'b0 || done_zero !== 1'b0) begin
         failures++; $display("FAIL single_done got=%0d/%b/%b exp=1/0/0", done_cnt, done_bout, done_zero); end
   endtask

   task automatic test_borrow_chain();
      xv[0] = 64'd0; yv[0] = 64'd1; xv[1] = 64'd1; yv[1] = 64'd0;
      run_op(2, 1'b0, 0);
      checks++; if (n_out !== 2 || got_d[0] !== ONES || got_d[1] !== 64'd0) begin
         failures++; $display("FAIL chain_words got=%0d/%h/%h exp=2/ffffffffffffffff/0", n_out, got_d[0], got_d[1]); end
      checks++; if (got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
         failures++; $display("FAIL chain_last got=%b%b exp=01", got_last[0], got_last[1]); end
      checks++; if (done_cnt !== 1 || done_bout !== 1'b0 || done_zero !== 1'b0) begin
         failures++; $display("FAIL chain_done got=%0d/%b/%b exp=1/0/0", done_cnt, done_bout, done_zero); end
   endtask

   task automatic test_zero_flag();
      xv[0] = 64'd0; yv[0] = 64'd0;
      run_op(1, 1'b0, 0);
      checks++; if (got_d[0] !== 64'd0 || done_zero !== 1'b1 || done_bout !== 1'b0) begin
         failures++; $display("FAIL zero_result got=%h/%b/%b exp=0/1/0", got_d[0], done_zero, done_bout); end
      checks++; if (zero !== 1'b1 || bout !== 1'b0) begin
         failures++; $display("FAIL zero_hold got=%b/%b exp=1/0", zero, bout); end
      xv[0] = 64'd0; yv[0] = 64'd1;
      run_op(1, 1'b0, 0);
      checks++; if (got_d[0] !== ONES || done_zero !== 1'b0 || done_bout !== 1'b1) begin
         failures++; $display("FAIL underflow got=%h/%b/%b exp=ffffffffffffffff/0/1", got_d[0], done_zero, done_bout); end
   endtask

   task automatic test_backpressure();
      xv[0] = 64'd10; yv[0] = 64'd1; xv[1] = 64'd20; yv[1] = 64'd2; xv[2] = 64'd30; yv[2] = 64'd3;
      run_op(3, 1'b0, 3);
      checks++; if (stall_viol !== 0) begin
         failures++; $display("FAIL stall_hold got=%0d exp=0 violations", stall_viol); end
      checks++; if (n_out !== 3 || got_d[0] !== 64'd9 || got_d[1] !== 64'd18 || got_d[2] !== 64'd27) begin
         failures++; $display("FAIL stall_order got=%0d/%0d/%0d/%0d exp=3/9/18/27", n_out, got_d[0], got_d[1], got_d[2]); end
      checks++; if (got_last[2] !== 1'b1 || got_last[1] !== 1'b0 || done_cnt !== 1) begin
         failures++; $display("FAIL stall_done got=%b%b/%0d exp=01/1", got_last[1], got_last[2], done_cnt); end
   endtask

   task automatic test_len0();
      run_op(0, 1'b1, 0);
      checks++; if (any_inready !== 1'b0 || n_out !== 0) begin
         failures++; $display("FAIL len0_input got=%b/%0d exp=0/0", any_inready, n_out); end
      checks++; if (done_at !== 0 || done_cnt !== 1 || done_bout !== 1'b1 || done_zero !== 1'b1) begin
         failures++; $display("FAIL len0_done got=%0d/%0d/%b/%b exp=0/1/1/1", done_at, done_cnt, done_bout, done_zero); end
   endtask

   task automatic test_back_to_back();
      xv[0] = 64'd0; yv[0] = 64'd1; xv[1] = 64'd0; yv[1] = 64'd0;
      xv[2] = 64'd5; yv[2] = 64'd0; xv[3] = 64'd7; yv[3] = 64'd7;
      run_op(4, 1'b1, 0);
      checks++; if (n_out !== 4 || got_d[0] !== 64'hFFFF_FFFF_FFFF_FFFE || got_d[1] !== ONES
                    || got_d[2] !== 64'd4 || got_d[3] !== 64'd0) begin
         failures++; $display("FAIL b2b_words got=%0d/%h/%h/%h/%h exp=4/fffffffffffffffe/ffffffffffffffff/4/0",
                              n_out, got_d[0], got_d[1], got_d[2], got_d[3]); end
      checks++; if (n_acc !== 4 || acc_last - acc_first !== 3) begin
         failures++; $display("FAIL b2b_rate got=%0d accepts over %0d cycles exp=4 over 3", n_acc, acc_last - acc_first); end
      checks++; if (done_bout !== 1'b0 || done_zero !== 1'b0 || done_cnt !== 1) begin
         failures++; $display("FAIL b2b_done got=%b/%b/%0d exp=0/0/1", done_bout, done_zero, done_cnt); end
   endtask

   task automatic test_reset_midop();
      start = 1'b1; len = 4'd4; bin_init = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; out_ready = 1'b0; in_valid = 1'b1; x_in = 64'd100; y_in = 64'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || d_out !== 64'd98 || busy !== 1'b1) begin
         failures++; $display("FAIL midop_pre got=%b/%0d/%b exp=1/98/1", out_valid, d_out, busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || d_out !== 64'd0 || out_last !== 1'b0 || busy !== 1'b0
                    || in_ready !== 1'b0 || done !== 1'b0 || bout !== 1'b0 || zero !== 1'b0) begin
         failures++; $display("FAIL midop_reset got=v%b d%h l%b b%b r%b dn%b bo%b z%b exp=all 0",
                              out_valid, d_out, out_last, busy, in_ready, done, bout, zero); end
      out_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      xv[0] = 64'd9; yv[0] = 64'd4;
      run_op(1, 1'b0, 0);
      checks++; if (n_out !== 1 || got_d[0] !== 64'd5 || done_bout !== 1'b0 || done_cnt !== 1) begin
         failures++; $display("FAIL midop_fresh got=%0d/%0d/%b/%0d exp=1/5/0/1", n_out, got_d[0], done_bout, done_cnt); end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_single();
      test_borrow_chain();
      test_zero_flag();
      test_backpressure();
      test_len0();
      test_back_to_back();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
